// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - byte-stream operand loader with double-buffered A/B/control staging
module operand_loader #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         kont_sign,
  output logic         op_valid,
  input  logic         op_ack,
  output logic         err,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_K = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         xfer;
  logic         ack_take;
  logic         ctrl_ok;

  // Only the control byte can overwrite a held set, so only S_K stalls on an unacknowledged set.
  always_comb begin
    din_ready = !(state == S_K && op_valid && !op_ack);
    xfer      = din_valid && din_ready;
    ack_take  = op_ack && op_valid;
    ctrl_ok   = (din[W-1:1] == '0);
  end

  // Staging FSM, output registers, ack handling and frame counter; a load wins over a clearing ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      a_s       <= '0;
      b_s       <= '0;
      a         <= '0;
      b         <= '0;
      kont_sign <= 1'b0;
      op_valid  <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      err <= 1'b0;
      if (ack_take) begin
        op_valid  <= 1'b0;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (xfer) begin
        case (state)
          S_A: begin
            a_s   <= din;
            state <= S_B;
          end
          S_B: begin
            b_s   <= din;
            state <= S_K;
          end
          S_K: begin
            if (ctrl_ok) begin
              a         <= a_s;
              b         <= b_s;
              kont_sign <= din[0];
              op_valid  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= S_A;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed and randomized scoreboard bench for operand_loader
module tb_operand_loader;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       kont_sign;
  logic       op_valid;
  logic       op_ack;
  logic       err;
  logic [7:0] frame_cnt;

  operand_loader #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .a         (a),
    .b         (b),
    .kont_sign (kont_sign),
    .op_valid  (op_valid),
    .op_ack    (op_ack),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  int checks = 0;
  int passed = 0;

  logic [16:0] sb[$];
  int          pos     = 0;
  logic [7:0]  sa      = 8'd0;
  logic [7:0]  sbyte   = 8'd0;
  bit          load_due = 0;
  bit          err_due  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void note_xfer(input logic [7:0] d);
    case (pos)
      0: sa = d;
      1: sbyte = d;
      default: begin
        if (d[7:1] == 7'd0) begin
          sb.push_back({sa, sbyte, d[0]});
          load_due = 1;
        end else begin
          err_due = 1;
        end
      end
    endcase
    pos = (pos + 1) % 3;
  endfunction

  task automatic send(input logic [7:0] d, input int gap);
    int n;
    din_valid = 1'b0;
    repeat (gap) step();
    din = d;
    din_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) chk("ready_timeout", {31'd0, din_ready}, 32'd1);
    step();
    din_valid = 1'b0;
    note_xfer(d);
  endtask

  task automatic ack_pulse();
    op_ack = 1'b1;
    step();
    op_ack = 1'b0;
  endtask

  // Scoreboard side: compare each freshly loaded set and the err pulse on the falling edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (load_due) begin
      load_due = 0;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("set_a", {24'd0, a}, {24'd0, e[16:9]});
        chk("set_b", {24'd0, b}, {24'd0, e[8:1]});
        chk("set_k", {31'd0, kont_sign}, {31'd0, e[0]});
        chk("set_valid", {31'd0, op_valid}, 32'd1);
      end
    end
    chk("err", {31'd0, err}, {31'd0, err_due});
    err_due = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rk;
    rst = 1'b1;
    din = 8'd0;
    din_valid = 1'b0;
    op_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_a", {24'd0, a}, 32'd0);
    chk("rst_b", {24'd0, b}, 32'd0);
    chk("rst_k", {31'd0, kont_sign}, 32'd0);
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);

    // single frame then acknowledge
    step();
    send(8'hFF, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    ack_pulse();
    @(negedge clk);
    chk("ack_valid", {31'd0, op_valid}, 32'd0);
    chk("ack_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("hold_a", {24'd0, a}, 32'hFF);
    chk("hold_b", {24'd0, b}, 32'h00);
    chk("hold_k", {31'd0, kont_sign}, 32'd1);

    // stall on control byte while a set is held, then overlap with ack
    step();
    send(8'h5A, 0);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'hFF, 0);
    send(8'h00, 0);
    din = 8'h00;
    din_valid = 1'b1;
    @(negedge clk);
    chk("stall_ready", {31'd0, din_ready}, 32'd0);
    step();
    op_ack = 1'b1;
    @(negedge clk);
    chk("ack_ready", {31'd0, din_ready}, 32'd1);
    step();
    din_valid = 1'b0;
    op_ack = 1'b0;
    note_xfer(8'h00);
    @(negedge clk);
    chk("b2b_valid", {31'd0, op_valid}, 32'd1);
    chk("b2b_cnt", {24'd0, frame_cnt}, 32'd2);
    step();
    ack_pulse();

    // malformed control byte drops the frame
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h03, 0);
    @(negedge clk);
    chk("bad_a", {24'd0, a}, 32'hFF);
    chk("bad_b", {24'd0, b}, 32'h00);
    chk("bad_valid", {31'd0, op_valid}, 32'd0);
    chk("bad_cnt", {24'd0, frame_cnt}, 32'd3);
    step();
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h00, 0);
    ack_pulse();

    // reset mid-frame discards staged bytes
    send(8'hAA, 0);
    send(8'hBB, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pos = 0;
    @(negedge clk);
    chk("mrst_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("mrst_valid", {31'd0, op_valid}, 32'd0);
    chk("mrst_ready", {31'd0, din_ready}, 32'd1);
    step();
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h01, 0);
    ack_pulse();

    // counter wrap with ack tied high
    rst = 1'b1;
    step();
    rst = 1'b0;
    pos = 0;
    op_ack = 1'b1;
    for (int i = 0; i < 255; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rk = 1'($urandom_range(0, 1));
      send(ra, 0);
      send(rb, 0);
      send({7'd0, rk}, 0);
    end
    repeat (2) step();
    @(negedge clk);
    chk("cnt_255", {24'd0, frame_cnt}, 32'd255);
    step();
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h00, 0);
    repeat (2) step();
    @(negedge clk);
    chk("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    chk("wrap_valid", {31'd0, op_valid}, 32'd0);
    op_ack = 1'b0;

    // stray ack while nothing is held
    step();
    ack_pulse();
    @(negedge clk);
    chk("stray_cnt", {24'd0, frame_cnt}, 32'd0);

    // random bubbles inside frames, some malformed controls
    step();
    op_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rk = 1'($urandom_range(0, 1));
      send(ra, $urandom_range(1, 5));
      send(rb, $urandom_range(1, 5));
      if (i % 5 == 4) send(8'h80, $urandom_range(1, 5));
      else send({7'd0, rk}, $urandom_range(1, 5));
    end
    repeat (2) step();
    op_ack = 1'b0;
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("bub_cnt", {24'd0, frame_cnt}, 32'd16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the 8-bit two-operand select/compute stage (inputs `a`, `b`, `kont_sign`; output `out`). It accepts a byte stream over a valid/ready handshake, assembles frames of A byte, B byte and control byte, and presents a complete operand set to the downstream stage. It holds the set with `op_valid` until the consumer acknowledges it. Staging is double-buffered, so the next frame can load while the current one is held.

## Interface
- `W`, 8, operand width; also the width of the byte stream.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  W  stream byte.
- `din_valid`  in  1  `din` holds a byte.
- `din_ready`  out  1  loader accepts `din` this cycle.
- `a`  out  W  operand A to the downstream stage.
- `b`  out  W  operand B to the downstream stage.
- `kont_sign`  out  1  control bit to the downstream stage.
- `op_valid`  out  1  `a`, `b` and `kont_sign` form a valid set.
- `op_ack`  in  1  consumer has taken the set.
- `err`  out  1  one-cycle pulse when a malformed control byte is dropped.
- `frame_cnt`  out  8  count of acknowledged sets; wraps 255→0.

## Operation
- **Transfer rule:** a byte is transferred when `din_valid && din_ready`. `din` is ignored in every other cycle.
- **Staging FSM** has three states: S_A, S_B, S_K.
  - S_A: on transfer, `a_s<=din`, go to S_B.
  - S_B: on transfer, `b_s<=din`, go to S_K.
  - S_K: on transfer, check the control byte.
    - If `din[W-1:1]==0`: `a<=a_s`, `b<=b_s`, `kont_sign<=din[0]`, `op_valid<=1`, go to S_A.
    - If `din[W-1:1]!=0`: drop the frame, `err<=1` for one cycle, outputs unchanged, `op_valid` unchanged, go to S_A.
- **Ready rule:** `din_ready = !(state==S_K && op_valid && !op_ack)`.
  - Always 1 in S_A and S_B, including while a set is held.
  - In S_K, stalls only while an unacknowledged set is pending.
- **Acknowledge rule:**
  - `op_ack && op_valid`: `op_valid<=0` next cycle and `frame_cnt<=frame_cnt+1` (mod 256).
  - `op_ack` while `op_valid==0`: ignored.
- **Back-to-back:** when a valid control byte transfers in the same cycle as `op_ack` on a held set:
  - outputs load the new set;
  - `op_valid` stays 1;
  - `frame_cnt` increments.
- **Output stability:** `a`, `b` and `kont_sign` change only on a valid-control transfer, and keep their last values after acknowledge.
- **Malformed control byte while a set is held:** the byte is still accepted only under the ready rule, i.e. only once the held set is being or has been acknowledged. It then raises `err` and the frame is dropped.
- **Reset values:**
  - `a`, `b`, `a_s`, `b_s`: 0
  - `kont_sign`, `op_valid`, `err`: 0
  - `frame_cnt`: 0
  - `din_ready`: 1
  - state: S_A
- **Reset mid-frame:** partially staged bytes are discarded. No `err` pulse and no `frame_cnt` change are produced by reset.

## Timing
- **Latency:** `op_valid` rises on the clock edge that captures the control byte, i.e. it is visible 1 cycle after the control-byte transfer cycle.
- **Minimum frame:** 3 transfer cycles. Sustained throughput is 1 set per 3 cycles when `op_ack` is tied high.
- `din_ready` is combinational from state, `op_valid` and `op_ack`. All other outputs are registered.
- `err` is high for exactly one cycle, the cycle after the offending transfer.
- **Reset priority:** `rst` overrides every simultaneous event, including transfer and ack.
- **Gaps:** `din_valid` low inside a frame inserts wait cycles without limit. There is no timeout.

## Test plan
- **Single frame:** reset, then stream 0xFF, 0x00, 0x01 on consecutive cycles → one cycle later `a=0xFF`, `b=0x00`, `kont_sign=1`, `op_valid=1`. Pulse `op_ack` → `op_valid=0`, `frame_cnt=1`, outputs hold.
- **Stall and overlap:** hold the set, stream 0xFF, 0x00, 0x00 with `op_ack` low.
  - A and B are accepted.
  - `din_ready=0` at the control byte.
  - Assert `op_ack` → control byte accepted that cycle, `kont_sign=0`, `op_valid` stays 1, `frame_cnt=2`.
- **Malformed control:** stream 0x12, 0x34, 0x03 → `err` pulses once, `a`, `b` and `op_valid` unchanged. The next frame 0x12, 0x34, 0x00 then presents `a=0x12`, `b=0x34`, `kont_sign=0`.
- **Reset mid-frame:** stream 0xAA, 0xBB, then `rst` for 1 cycle, then 0x11, 0x22, 0x01 → `a=0x11`, `b=0x22`, `kont_sign=1`, no `err`.
- **Counter wrap and stray ack:**
  - Run 256 acknowledged frames with `op_ack` high → `frame_cnt` goes 255→0.
  - `op_ack` pulsed while `op_valid=0` → no count change.
- **Bubbles:** random `din_valid` gaps, 1–5 cycles, inside frames → every set matches a scoreboard built from the transferred bytes.
